// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: stage load enables, hazard bubbles,
// taken-branch flush, saturating perf counters and a memory-wait watchdog.
module pipeline_stall_ctrl #(
    parameter int unsigned CNT_WIDTH = 32,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_imem_read,
    input  logic                 i_imem_resp,
    input  logic                 i_dmem_read,
    input  logic                 i_dmem_write,
    input  logic                 i_dmem_resp,
    input  logic [4:0]           i_id_rs1,
    input  logic [4:0]           i_id_rs2,
    input  logic                 i_id_use_rs1,
    input  logic                 i_id_use_rs2,
    input  logic                 i_id_is_jb,
    input  logic                 i_id_pc_mux_sel,
    input  logic [4:0]           i_ex_rd,
    input  logic                 i_ex_load_regfile,
    input  logic                 i_ex_is_load,
    input  logic [4:0]           i_mem_rd,
    input  logic                 i_mem_load_regfile,
    input  logic                 i_mem_is_load,
    output logic                 o_pc_load_c,
    output logic                 o_if_id_load_c,
    output logic                 o_id_ex_load_c,
    output logic                 o_ex_mem_load_c,
    output logic                 o_mem_wb_load_c,
    output logic                 o_if_id_flush_c,
    output logic                 o_id_ex_bubble_c,
    output logic [CNT_WIDTH-1:0] o_stall_cycles,
    output logic [CNT_WIDTH-1:0] o_flush_count,
    output logic                 o_timeout_err
);

    localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);
    localparam logic WDOG_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_HAZ      = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [WAIT_W-1:0]     r_wait_cnt;
    logic [CNT_WIDTH-1:0]  r_stall_cycles;
    logic [CNT_WIDTH-1:0]  r_flush_count;
    logic                  r_timeout_err;

    logic w_mem_busy;
    logic w_ex_m1, w_ex_m2, w_mem_m1, w_mem_m2;
    logic w_hz_rs1, w_hz_rs2, w_hz;

    assign w_mem_busy = (i_imem_read & ~i_imem_resp)
                      | ((i_dmem_read | i_dmem_write) & ~i_dmem_resp);

    assign w_ex_m1  = (i_id_rs1 != 5'd0) && (i_id_rs1 == i_ex_rd)  && i_ex_load_regfile;
    assign w_ex_m2  = (i_id_rs2 != 5'd0) && (i_id_rs2 == i_ex_rd)  && i_ex_load_regfile;
    assign w_mem_m1 = (i_id_rs1 != 5'd0) && (i_id_rs1 == i_mem_rd) && i_mem_load_regfile;
    assign w_mem_m2 = (i_id_rs2 != 5'd0) && (i_id_rs2 == i_mem_rd) && i_mem_load_regfile;

    // Branches resolve in ID with no EX forwarding, so any in-flight producer stalls a jb.
    assign w_hz_rs1 = i_id_use_rs1 && ((w_ex_m1 && (i_ex_is_load || i_id_is_jb))
                                    || (w_mem_m1 && i_mem_is_load && i_id_is_jb));
    assign w_hz_rs2 = i_id_use_rs2 && ((w_ex_m2 && (i_ex_is_load || i_id_is_jb))
                                    || (w_mem_m2 && i_mem_is_load && i_id_is_jb));
    assign w_hz     = w_hz_rs1 || w_hz_rs2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and stage controls; memory freeze outranks hazards, hazards outrank flush.
    always_comb begin
        w_next_state     = r_state;
        o_pc_load_c      = 1'b0;
        o_if_id_load_c   = 1'b0;
        o_id_ex_load_c   = 1'b0;
        o_ex_mem_load_c  = 1'b0;
        o_mem_wb_load_c  = 1'b0;
        o_if_id_flush_c  = 1'b0;
        o_id_ex_bubble_c = 1'b0;

        if (w_mem_busy) begin
            w_next_state = ST_MEM_WAIT;
        end else if (w_hz) begin
            w_next_state = ST_HAZ;
        end else begin
            w_next_state = ST_RUN;
        end

        if (rst || w_mem_busy) begin
            o_pc_load_c = 1'b0;
        end else if (w_hz) begin
            o_id_ex_load_c   = 1'b1;
            o_ex_mem_load_c  = 1'b1;
            o_mem_wb_load_c  = 1'b1;
            o_id_ex_bubble_c = 1'b1;
        end else begin
            o_pc_load_c     = 1'b1;
            o_if_id_load_c  = 1'b1;
            o_id_ex_load_c  = 1'b1;
            o_ex_mem_load_c = 1'b1;
            o_mem_wb_load_c = 1'b1;
            o_if_id_flush_c = i_id_pc_mux_sel;
        end
    end

    // Watchdog: wait_cnt holds at TIMEOUT so the sticky flag never sees a wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else if (r_state == ST_MEM_WAIT) begin
            if (r_wait_cnt != WAIT_MAX) begin
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            end
            if (WDOG_EN && ((r_wait_cnt + WAIT_W'(1)) == WAIT_MAX)) begin
                r_timeout_err <= 1'b1;
            end
        end else begin
            r_wait_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (!o_pc_load_c && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + CNT_WIDTH'(1);
            end
            if (o_if_id_flush_c && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + CNT_WIDTH'(1);
            end
        end
    end

    assign o_stall_cycles = r_stall_cycles;
    assign o_flush_count  = r_flush_count;
    assign o_timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: the driver queues hand-computed responses,
// a negedge monitor pops and compares them against the DUT.
module tb_pipeline_stall_ctrl;

    typedef struct packed {
        logic       rst;
        logic       imem_read;
        logic       imem_resp;
        logic       dmem_read;
        logic       dmem_write;
        logic       dmem_resp;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic       jb;
        logic       pcsel;
        logic [4:0] ex_rd;
        logic       ex_rf;
        logic       ex_ld;
        logic [4:0] mem_rd;
        logic       mem_rf;
        logic       mem_ld;
    } stim_t;

    typedef struct packed {
        logic [4:0] en;
        logic       fl;
        logic       bb;
        logic [3:0] st;
        logic [3:0] fc;
        logic       to;
        logic [1:0] state;
    } exp_t;

    localparam logic [4:0] ALL = 5'b11111;
    localparam logic [4:0] FRZ = 5'b00000;
    localparam logic [4:0] HZE = 5'b00111;
    localparam logic [1:0] RUN = 2'd0;
    localparam logic [1:0] HAZ = 2'd1;
    localparam logic [1:0] MW  = 2'd2;

    logic       clk;
    logic       rst;
    logic       imem_read, imem_resp, dmem_read, dmem_write, dmem_resp;
    logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd;
    logic       id_use_rs1, id_use_rs2, id_is_jb, id_pc_mux_sel;
    logic       ex_load_regfile, ex_is_load, mem_load_regfile, mem_is_load;
    logic       pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
    logic       if_id_flush, id_ex_bubble, timeout_err;
    logic [3:0] stall_cycles, flush_count;

    exp_t  exp_q[$];
    string name_q[$];
    int    errors = 0;
    int    checks = 0;

    pipeline_stall_ctrl #(.CNT_WIDTH(4), .TIMEOUT(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .i_imem_read        (imem_read),
        .i_imem_resp        (imem_resp),
        .i_dmem_read        (dmem_read),
        .i_dmem_write       (dmem_write),
        .i_dmem_resp        (dmem_resp),
        .i_id_rs1           (id_rs1),
        .i_id_rs2           (id_rs2),
        .i_id_use_rs1       (id_use_rs1),
        .i_id_use_rs2       (id_use_rs2),
        .i_id_is_jb         (id_is_jb),
        .i_id_pc_mux_sel    (id_pc_mux_sel),
        .i_ex_rd            (ex_rd),
        .i_ex_load_regfile  (ex_load_regfile),
        .i_ex_is_load       (ex_is_load),
        .i_mem_rd           (mem_rd),
        .i_mem_load_regfile (mem_load_regfile),
        .i_mem_is_load      (mem_is_load),
        .o_pc_load_c        (pc_load),
        .o_if_id_load_c     (if_id_load),
        .o_id_ex_load_c     (id_ex_load),
        .o_ex_mem_load_c    (ex_mem_load),
        .o_mem_wb_load_c    (mem_wb_load),
        .o_if_id_flush_c    (if_id_flush),
        .o_id_ex_bubble_c   (id_ex_bubble),
        .o_stall_cycles     (stall_cycles),
        .o_flush_count      (flush_count),
        .o_timeout_err      (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t ex_wr(input stim_t b, input logic [4:0] rd, input logic ld);
        stim_t s;
        s = b;
        s.ex_rd = rd;
        s.ex_rf = 1'b1;
        s.ex_ld = ld;
        return s;
    endfunction

    function automatic stim_t mem_wr(input stim_t b, input logic [4:0] rd, input logic ld);
        stim_t s;
        s = b;
        s.mem_rd = rd;
        s.mem_rf = 1'b1;
        s.mem_ld = ld;
        return s;
    endfunction

    function automatic stim_t id_rd(input stim_t b, input logic [4:0] r1, input logic u1,
                                    input logic [4:0] r2, input logic u2,
                                    input logic jb, input logic pcsel);
        stim_t s;
        s = b;
        s.rs1 = r1;
        s.use1 = u1;
        s.rs2 = r2;
        s.use2 = u2;
        s.jb = jb;
        s.pcsel = pcsel;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        rst              = s.rst;
        imem_read        = s.imem_read;
        imem_resp        = s.imem_resp;
        dmem_read        = s.dmem_read;
        dmem_write       = s.dmem_write;
        dmem_resp        = s.dmem_resp;
        id_rs1           = s.rs1;
        id_rs2           = s.rs2;
        id_use_rs1       = s.use1;
        id_use_rs2       = s.use2;
        id_is_jb         = s.jb;
        id_pc_mux_sel    = s.pcsel;
        ex_rd            = s.ex_rd;
        ex_load_regfile  = s.ex_rf;
        ex_is_load       = s.ex_ld;
        mem_rd           = s.mem_rd;
        mem_load_regfile = s.mem_rf;
        mem_is_load      = s.mem_ld;
    endtask

    // One cycle: inputs just after posedge; counters/state expected are those after that edge.
    task automatic step(input stim_t s, input logic [4:0] en, input logic fl, input logic bb,
                        input int st, input int fc, input logic to, input logic [1:0] stt,
                        input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        apply(s);
        e.en = en; e.fl = fl; e.bb = bb;
        e.st = 4'(st); e.fc = 4'(fc); e.to = to; e.state = stt;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic do_reset();
        stim_t s;
        s = idle();
        s.rst = 1'b1;
        step(s, FRZ, 1'b0, 1'b0, 0, 0, 1'b0, RUN, "reset");
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            exp_t  a;
            string nm;
            e = exp_q.pop_front();
            nm = name_q.pop_front();
            a.en = {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load};
            a.fl = if_id_flush;
            a.bb = id_ex_bubble;
            a.st = stall_cycles;
            a.fc = flush_count;
            a.to = timeout_err;
            a.state = 2'(dut.r_state);
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got en=%b fl=%b bb=%b st=%0d fc=%0d to=%b state=%0d, expected en=%b fl=%b bb=%b st=%0d fc=%0d to=%b state=%0d",
                         nm, a.en, a.fl, a.bb, a.st, a.fc, a.to, a.state,
                         e.en, e.fl, e.bb, e.st, e.fc, e.to, e.state);
            end
        end
    end

    initial begin
        stim_t s;
        s = idle();
        s.rst = 1'b1;
        apply(s);

        // Load-use: one bubble.
        do_reset();
        do_reset();
        step(idle(), ALL, 0, 0, 0, 0, 0, RUN, "lu_pre");
        s = id_rd(ex_wr(idle(), 5'd5, 1'b1), 5'd5, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0);
        step(s, HZE, 0, 1, 0, 0, 0, RUN, "lu_stall");
        step(idle(), ALL, 0, 0, 1, 0, 0, HAZ, "lu_release");
        step(idle(), ALL, 0, 0, 1, 0, 0, RUN, "lu_after");

        // Branch on EX ALU result: one bubble.
        do_reset();
        s = id_rd(ex_wr(idle(), 5'd7, 1'b0), 5'd7, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0);
        step(s, HZE, 0, 1, 0, 0, 0, RUN, "jb_alu_stall");
        s = id_rd(mem_wr(idle(), 5'd7, 1'b0), 5'd7, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0);
        step(s, ALL, 0, 0, 1, 0, 0, HAZ, "jb_alu_go");
        step(idle(), ALL, 0, 0, 1, 0, 0, RUN, "jb_alu_after");

        // Branch on EX load: two bubbles, then taken flush.
        do_reset();
        s = id_rd(ex_wr(idle(), 5'd7, 1'b1), 5'd7, 1'b1, 5'd0, 1'b1, 1'b1, 1'b1);
        step(s, HZE, 0, 1, 0, 0, 0, RUN, "jb_ld_ex");
        s = id_rd(mem_wr(idle(), 5'd7, 1'b1), 5'd7, 1'b1, 5'd0, 1'b1, 1'b1, 1'b1);
        step(s, HZE, 0, 1, 1, 0, 0, HAZ, "jb_ld_mem");
        s = id_rd(idle(), 5'd7, 1'b1, 5'd0, 1'b1, 1'b1, 1'b1);
        step(s, ALL, 1, 0, 2, 0, 0, HAZ, "jb_taken");
        step(idle(), ALL, 0, 0, 2, 1, 0, RUN, "jb_after");

        // Fetch freeze masks a taken branch; watchdog trips after 4 wait cycles.
        do_reset();
        s = id_rd(idle(), 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        s.imem_read = 1'b1;
        for (int i = 0; i < 5; i++)
            step(s, FRZ, 0, 0, i, 0, 0, (i == 0) ? RUN : MW, "imem_freeze");
        s.imem_resp = 1'b1;
        step(s, ALL, 1, 0, 5, 0, 1, MW, "imem_release");
        step(idle(), ALL, 0, 0, 5, 1, 1, RUN, "imem_after");

        // Data freeze together with load-use hazard: freeze first, then one bubble.
        do_reset();
        s = id_rd(ex_wr(idle(), 5'd5, 1'b1), 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        s.dmem_read = 1'b1;
        for (int i = 0; i < 3; i++)
            step(s, FRZ, 0, 0, i, 0, 0, (i == 0) ? RUN : MW, "dmem_freeze_hz");
        s.dmem_resp = 1'b1;
        step(s, HZE, 0, 1, 3, 0, 0, MW, "dmem_release_hz");
        step(idle(), ALL, 0, 0, 4, 0, 0, HAZ, "dmem_bubble_done");
        step(idle(), ALL, 0, 0, 4, 0, 0, RUN, "dmem_run");

        // Unanswered store: sticky timeout, then reset mid-freeze.
        do_reset();
        s = idle();
        s.dmem_write = 1'b1;
        for (int i = 0; i < 6; i++)
            step(s, FRZ, 0, 0, i, 0, (i == 5), (i == 0) ? RUN : MW, "wdog_wait");
        s.dmem_resp = 1'b1;
        step(s, ALL, 0, 0, 6, 0, 1, MW, "wdog_resp");
        s.dmem_resp = 1'b0;
        step(s, FRZ, 0, 0, 6, 0, 1, RUN, "wdog_sticky");
        step(s, FRZ, 0, 0, 7, 0, 1, MW, "wdog_refreeze");
        s.rst = 1'b1;
        step(s, FRZ, 0, 0, 0, 0, 0, RUN, "rst_mid_freeze");
        step(idle(), ALL, 0, 0, 0, 0, 0, RUN, "rst_after");

        // Non-hazards: x0, unused rs2, MEM load to non-jb, MEM ALU to jb; then rs2 load-use.
        do_reset();
        s = mem_wr(id_rd(ex_wr(idle(), 5'd0, 1'b1), 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0), 5'd0, 1'b1);
        step(s, ALL, 0, 0, 0, 0, 0, RUN, "x0_no_stall");
        s = id_rd(ex_wr(idle(), 5'd9, 1'b1), 5'd3, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
        step(s, ALL, 0, 0, 0, 0, 0, RUN, "rs2_unused");
        s = id_rd(mem_wr(idle(), 5'd4, 1'b1), 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        step(s, ALL, 0, 0, 0, 0, 0, RUN, "mem_load_nonjb");
        s = id_rd(mem_wr(idle(), 5'd4, 1'b0), 5'd4, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0);
        step(s, ALL, 0, 0, 0, 0, 0, RUN, "jb_mem_alu");
        s = id_rd(ex_wr(idle(), 5'd9, 1'b1), 5'd3, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        step(s, HZE, 0, 1, 0, 0, 0, RUN, "rs2_loaduse");
        step(idle(), ALL, 0, 0, 1, 0, 0, HAZ, "rs2_after");

        // Stall counter saturates at 15 with CNT_WIDTH=4.
        do_reset();
        s = id_rd(ex_wr(idle(), 5'd5, 1'b1), 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int n = 1; n <= 17; n++)
            step(s, HZE, 0, 1, (n - 1 > 15) ? 15 : n - 1, 0, 0, (n == 1) ? RUN : HAZ, "sat_stall");
        step(idle(), ALL, 0, 0, 15, 0, 0, HAZ, "sat_hold");
        step(idle(), ALL, 0, 0, 15, 0, 0, RUN, "sat_hold2");

        for (int i = 0; i < 8 && exp_q.size() != 0; i++)
            @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d entries left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
